line_hit_monitor: RTL and testbench
===================================

# line_hit_monitor

Reads the pixel stream produced by a horizontal obstacle-line renderer and judges the player against it. Each frame it checks for overlap between the line pixels and the player pixels and tracks the player's vertical position relative to the line band. At frame boundaries it issues a collision or pass-through result and maintains a score. It sits between the line and player renderers and the game-control logic, on the pixel clock domain.

## Interface
Parameters:
- LINE_TOP, 378, first row of the line band
- LINE_BOT, 386, last row of the line band
- PLAYER_H, 16, player block height in rows
- HIT_FRAMES, 2, consecutive overlap frames required to declare a collision (1..15)

Ports:
- clk  input  1  pixel clock; the block's only clock
- reset  input  1  synchronous, active-high reset
- frame  input  1  one-clk pulse marking end of frame; all decisions happen here
- enable  input  1  game running; low forces IDLE
- h_line  input  1  line pixel active at current scan position
- player  input  1  player pixel active at current scan position
- player_y  input  16  player top row, stable across the frame pulse
- clear_score  input  1  synchronous score clear
- collide  output  1  one-clk collision pulse
- pass  output  1  one-clk pass-through pulse
- hit_latched  output  1  level, high while in HIT
- score  output  8  passes counted
- state  output  3  current FSM state, for debug

## Operation
- Overlap latch `ov`:
  - Set on any clk with `h_line & player & enable`.
  - At a `frame` pulse, `ov` is sampled and then cleared.
  - An overlap in the same cycle as `frame` counts toward the frame being closed.
- Band test at `frame`, in 17-bit arithmetic:
  - above = `player_y + PLAYER_H - 1 < LINE_TOP`
  - below = `player_y > LINE_BOT`
  - in_band = neither above nor below
- Consecutive-hit counter, 4 bits:
  - At `frame`, increments if the sampled `ov` is set, otherwise clears to 0.
  - Saturates at HIT_FRAMES.
- States, all transitions only at `frame`:
  - IDLE=0: moves to ABOVE if above, otherwise to BELOW.
  - ABOVE=1: moves to IN_BAND when in_band; moves to BELOW when below (jumped the band, no pass).
  - IN_BAND=2: moves to BELOW when below with no collision, and pulses `pass`. Returns to ABOVE when above.
  - BELOW=3: moves to ABOVE when above, which starts a new round.
  - HIT=4: sticky. Exits only through `enable` low or `reset`.
- Collision: in any of ABOVE, IN_BAND or BELOW, if the counter reaches HIT_FRAMES at `frame`, the FSM moves to HIT and pulses `collide`.
  - Collision has priority over pass in the same frame; `pass` is not issued.
- `enable` low:
  - Forces IDLE on the next clk.
  - Clears `ov` and the counter.
  - `score` is retained.
- Score:
  - Increments on each `pass`.
  - `clear_score` wins over a simultaneous pass, giving `score` = 0.

## Timing
- `collide` and `pass` are registered. They are high exactly one clk, the cycle after the `frame` pulse.
- `state`, `hit_latched` and `score` update in that same cycle.
- Reset, synchronous:
  - state = IDLE
  - collide = 0, pass = 0, hit_latched = 0, score = 0
  - `ov` and the counter are cleared
- Reset mid-frame: overlaps seen earlier in the frame are discarded.
- Back-to-back `frame` pulses on consecutive clks are legal. Each is evaluated independently.

## Configuration
- `LINE_HIT_SCORE_SAT_EN`:
  - Defined: `score` saturates at 255, and further passes still pulse `pass`.
  - Undefined: `score` wraps from 255 to 0.

## Test plan
- Reset, then `enable` = 1 with `player_y` = 300, then one `frame` → state = ABOVE, all pulses 0, score = 0.
- `player_y` 300 → 375 → 390 across three frames with no overlap → `pass` pulses once after the third frame, score = 1, state = BELOW.
- HIT_FRAMES = 2, `player_y` = 375, `h_line & player` asserted in two consecutive frames → `collide` pulse after the second frame, hit_latched = 1. A later move to `player_y` = 390 produces no `pass`.
- Overlap in one frame only, then a clean frame, then an overlap again → no `collide`, because the counter resets to 0.
- Overlap asserted in the same cycle as `frame`, while that closing frame moves the player from IN_BAND to below (`player_y` = 390), with HIT_FRAMES = 1 → `collide` = 1, `pass` = 0, score unchanged.
- score = 255, then a pass → score = 255 with the macro defined and 0 without. `clear_score` coincident with a pass → score = 0.

Source files
------------

// File: rtl/line_hit_if.sv
// Bundles the renderer pixel inputs, game-control inputs and judgement outputs of line_hit_monitor.
// master drives the pixel/control side; slave is the monitor itself.
interface line_hit_if;
    logic        frame;
    logic        enable;
    logic        h_line;
    logic        player;
    logic [15:0] player_y;
    logic        clear_score;
    logic        collide;
    logic        pass;
    logic        hit_latched;
    logic [7:0]  score;
    logic [2:0]  state;

    modport master (
        output frame, enable, h_line, player, player_y, clear_score,
        input  collide, pass, hit_latched, score, state
    );

    modport slave (
        input  frame, enable, h_line, player, player_y, clear_score,
        output collide, pass, hit_latched, score, state
    );
endinterface

// File: rtl/line_hit_monitor.sv
// Judges the player against a horizontal obstacle band: overlap-based collision, pass-through scoring.
// Optional macro LINE_HIT_SCORE_SAT_EN: score saturates at 255 instead of wrapping.
module line_hit_monitor #(
    parameter int LINE_TOP   = 378,
    parameter int LINE_BOT   = 386,
    parameter int PLAYER_H   = 16,
    parameter int HIT_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    line_hit_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ABOVE   = 3'd1,
        IN_BAND = 3'd2,
        BELOW   = 3'd3,
        HIT     = 3'd4
    } state_t;

    localparam logic [3:0]  HIT_LIM = 4'(HIT_FRAMES);
    localparam logic [16:0] TOP_17  = 17'(LINE_TOP);
    localparam logic [16:0] BOT_17  = 17'(LINE_BOT);
    localparam logic [16:0] HGT_17  = 17'(PLAYER_H);

    state_t      r_state;
    logic        r_ov;
    logic [3:0]  r_cnt;
    logic        r_collide;
    logic        r_pass;
    logic        r_hitLatched;
    logic [7:0]  r_score;

    state_t      w_stateNext;
    logic        w_ovNow;
    logic        w_ovSample;
    logic        w_ovNext;
    logic [3:0]  w_cntNext;
    logic        w_collideNext;
    logic        w_passNext;
    logic [7:0]  w_scoreInc;
    logic [7:0]  w_scoreNext;
    logic [16:0] w_playerTop;
    logic [16:0] w_playerBot;
    logic        w_above;
    logic        w_below;
    logic        w_inBand;
    logic        w_inRound;

    assign w_ovNow     = bus.h_line & bus.player & bus.enable;
    assign w_ovSample  = r_ov | w_ovNow;
    assign w_playerTop = {1'b0, bus.player_y};
    assign w_playerBot = w_playerTop + HGT_17 - 17'd1;
    assign w_above     = (w_playerBot < TOP_17);
    assign w_below     = (w_playerTop > BOT_17);
    assign w_inBand    = ~w_above & ~w_below;
    assign w_inRound   = (r_state == ABOVE) || (r_state == IN_BAND) || (r_state == BELOW);

    // Overlap latch and consecutive-hit counter; the frame pulse closes the frame, including its own overlap.
    always_comb begin
        w_ovNext  = w_ovSample;
        w_cntNext = r_cnt;
        if (!bus.enable) begin
            w_ovNext  = 1'b0;
            w_cntNext = 4'd0;
        end else if (bus.frame) begin
            w_ovNext = 1'b0;
            if (w_ovSample) begin
                w_cntNext = (r_cnt >= HIT_LIM) ? HIT_LIM : r_cnt + 4'd1;
            end else begin
                w_cntNext = 4'd0;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_collideNext = 1'b0;
        w_passNext    = 1'b0;
        if (!bus.enable) begin
            w_stateNext = IDLE;
        end else if (bus.frame) begin
            if (w_inRound && (w_cntNext == HIT_LIM)) begin
                w_stateNext   = HIT;
                w_collideNext = 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        w_stateNext = w_above ? ABOVE : BELOW;
                    end
                    ABOVE: begin
                        if (w_inBand) begin
                            w_stateNext = IN_BAND;
                        end else if (w_below) begin
                            w_stateNext = BELOW;
                        end
                    end
                    IN_BAND: begin
                        if (w_below) begin
                            w_stateNext = BELOW;
                            w_passNext  = 1'b1;
                        end else if (w_above) begin
                            w_stateNext = ABOVE;
                        end
                    end
                    BELOW: begin
                        if (w_above) begin
                            w_stateNext = ABOVE;
                        end
                    end
                    HIT: begin
                        w_stateNext = HIT;
                    end
                    default: begin
                        w_stateNext = IDLE;
                    end
                endcase
            end
        end
    end

`ifdef LINE_HIT_SCORE_SAT_EN
    assign w_scoreInc = (r_score == 8'hFF) ? 8'hFF : r_score + 8'd1;
`else
    assign w_scoreInc = r_score + 8'd1;
`endif

    // A clear wins over a same-cycle pass.
    always_comb begin
        w_scoreNext = r_score;
        if (bus.clear_score) begin
            w_scoreNext = 8'd0;
        end else if (w_passNext) begin
            w_scoreNext = w_scoreInc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ov         <= 1'b0;
            r_cnt        <= 4'd0;
            r_collide    <= 1'b0;
            r_pass       <= 1'b0;
            r_hitLatched <= 1'b0;
            r_score      <= 8'd0;
        end else begin
            r_state      <= w_stateNext;
            r_ov         <= w_ovNext;
            r_cnt        <= w_cntNext;
            r_collide    <= w_collideNext;
            r_pass       <= w_passNext;
            r_hitLatched <= (w_stateNext == HIT);
            r_score      <= w_scoreNext;
        end
    end

    assign bus.collide     = r_collide;
    assign bus.pass        = r_pass;
    assign bus.hit_latched = r_hitLatched;
    assign bus.score       = r_score;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_line_hit_monitor.sv
// Self-checking bench for line_hit_monitor: two instances (HIT_FRAMES 2 and 1) on shared stimulus,
// checked every clock against a positional reference model, plus directed scenario checks.
module tb_line_hit_monitor;

    localparam int TOP = 378;
    localparam int BOT = 386;
    localparam int PH  = 16;
    localparam int S_IDLE = 0, S_ABOVE = 1, S_INBAND = 2, S_BELOW = 3, S_HIT = 4;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nErrors = 0;

    int mState [2];
    int mOv    [2];
    int mCnt   [2];
    int mScore [2];
    int mCol   [2];
    int mPass  [2];
    int hfOf   [2] = '{2, 1};

    line_hit_if ifA ();
    line_hit_if ifB ();

    assign ifB.frame       = ifA.frame;
    assign ifB.enable      = ifA.enable;
    assign ifB.h_line      = ifA.h_line;
    assign ifB.player      = ifA.player;
    assign ifB.player_y    = ifA.player_y;
    assign ifB.clear_score = ifA.clear_score;

    line_hit_monitor #(.LINE_TOP(TOP), .LINE_BOT(BOT), .PLAYER_H(PH), .HIT_FRAMES(2))
        dutA (.clk(clk), .reset(rst), .bus(ifA));
    line_hit_monitor #(.LINE_TOP(TOP), .LINE_BOT(BOT), .PLAYER_H(PH), .HIT_FRAMES(1))
        dutB (.clk(clk), .reset(rst), .bus(ifB));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: judges each frame by where the player sits relative to the band.
    task automatic modelStep(input int k);
        int  y;
        bit  above, below, seen, hp;
        int  hf;
        hf = hfOf[k];
        mCol[k]  = 0;
        mPass[k] = 0;
        hp = (ifA.h_line === 1'b1) && (ifA.player === 1'b1);
        if (rst) begin
            mState[k] = S_IDLE; mOv[k] = 0; mCnt[k] = 0; mScore[k] = 0;
            return;
        end
        if (ifA.enable !== 1'b1) begin
            mState[k] = S_IDLE; mOv[k] = 0; mCnt[k] = 0;
        end else if (ifA.frame === 1'b1) begin
            seen   = (mOv[k] != 0) || hp;
            mOv[k] = 0;
            mCnt[k] = seen ? ((mCnt[k] + 1 > hf) ? hf : mCnt[k] + 1) : 0;
            y     = int'(ifA.player_y);
            above = (y + PH - 1) < TOP;
            below = y > BOT;
            if (mState[k] >= S_ABOVE && mState[k] <= S_BELOW && mCnt[k] == hf) begin
                mState[k] = S_HIT;
                mCol[k]   = 1;
            end else if (mState[k] == S_IDLE) begin
                mState[k] = above ? S_ABOVE : S_BELOW;
            end else if (mState[k] == S_ABOVE) begin
                if (below) mState[k] = S_BELOW;
                else if (!above) mState[k] = S_INBAND;
            end else if (mState[k] == S_INBAND) begin
                if (below) begin
                    mState[k] = S_BELOW;
                    mPass[k]  = 1;
                end else if (above) begin
                    mState[k] = S_ABOVE;
                end
            end else if (mState[k] == S_BELOW && above) begin
                mState[k] = S_ABOVE;
            end
        end else if (hp) begin
            mOv[k] = 1;
        end
        if (ifA.clear_score === 1'b1) begin
            mScore[k] = 0;
        end else if (mPass[k] != 0) begin
`ifdef LINE_HIT_SCORE_SAT_EN
            mScore[k] = (mScore[k] >= 255) ? 255 : mScore[k] + 1;
`else
            mScore[k] = (mScore[k] + 1) % 256;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkOutput("A.state",   ifA.state,       mState[0]);
        checkOutput("A.collide", ifA.collide,     mCol[0]);
        checkOutput("A.pass",    ifA.pass,        mPass[0]);
        checkOutput("A.hit",     ifA.hit_latched, (mState[0] == S_HIT));
        checkOutput("A.score",   ifA.score,       mScore[0]);
        checkOutput("B.state",   ifB.state,       mState[1]);
        checkOutput("B.collide", ifB.collide,     mCol[1]);
        checkOutput("B.pass",    ifB.pass,        mPass[1]);
        checkOutput("B.hit",     ifB.hit_latched, (mState[1] == S_HIT));
        checkOutput("B.score",   ifB.score,       mScore[1]);
    endtask

    task automatic applyStimulus(input bit fr, input int y, input bit hp, input bit en, input bit clr);
        ifA.frame       = fr;
        ifA.player_y    = 16'(y);
        ifA.h_line      = hp;
        ifA.player      = hp;
        ifA.enable      = en;
        ifA.clear_score = clr;
        tick();
        ifA.frame       = 1'b0;
        ifA.h_line      = 1'b0;
        ifA.player      = 1'b0;
        ifA.clear_score = 1'b0;
    endtask

    initial begin
        int scoreBefore;
        int y;
        rst = 1'b1;
        ifA.frame = 1'b0; ifA.enable = 1'b0; ifA.h_line = 1'b0; ifA.player = 1'b0;
        ifA.player_y = 16'd300; ifA.clear_score = 1'b0;
        tick();
        tick();
        checkOutput("reset.state", ifA.state, S_IDLE);
        checkOutput("reset.score", ifA.score, 0);
        rst = 1'b0;

        // First frame above the band.
        applyStimulus(1'b0, 300, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 300, 1'b0, 1'b1, 1'b0);
        checkOutput("first.state", ifA.state, S_ABOVE);
        checkOutput("first.pass",  ifA.pass, 0);

        // Clean pass-through.
        applyStimulus(1'b1, 375, 1'b0, 1'b1, 1'b0);
        checkOutput("pass.inband", ifA.state, S_INBAND);
        applyStimulus(1'b1, 390, 1'b0, 1'b1, 1'b0);
        checkOutput("pass.pulse", ifA.pass, 1);
        checkOutput("pass.score", ifA.score, 1);
        checkOutput("pass.state", ifA.state, S_BELOW);
        applyStimulus(1'b0, 390, 1'b0, 1'b1, 1'b0);
        checkOutput("pass.oneclk", ifA.pass, 0);

        // Two consecutive overlap frames collide on A, one is enough for B.
        applyStimulus(1'b0, 375, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 375, 1'b0, 1'b1, 1'b0);
        checkOutput("hit1.A.collide", ifA.collide, 0);
        checkOutput("hit1.B.collide", ifB.collide, 1);
        applyStimulus(1'b1, 375, 1'b1, 1'b1, 1'b0);
        checkOutput("hit2.A.collide", ifA.collide, 1);
        checkOutput("hit2.A.latched", ifA.hit_latched, 1);
        applyStimulus(1'b1, 390, 1'b0, 1'b1, 1'b0);
        checkOutput("hit.nopass", ifA.pass, 0);
        checkOutput("hit.sticky", ifA.state, S_HIT);

        // Interrupted overlap restarts the count.
        applyStimulus(1'b0, 300, 1'b0, 1'b0, 1'b0);
        checkOutput("dis.idle", ifA.state, S_IDLE);
        checkOutput("dis.score", ifA.score, 1);
        applyStimulus(1'b1, 300, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 380, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 380, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 380, 1'b1, 1'b1, 1'b0);
        checkOutput("gap.nocollide", ifA.collide, 0);
        checkOutput("gap.state", ifA.state, S_INBAND);

        // Overlap on the closing frame while leaving the band.
        applyStimulus(1'b0, 300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 300, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 380, 1'b0, 1'b1, 1'b0);
        scoreBefore = int'(ifB.score);
        applyStimulus(1'b1, 390, 1'b1, 1'b1, 1'b0);
        checkOutput("late.B.collide", ifB.collide, 1);
        checkOutput("late.B.pass", ifB.pass, 0);
        checkOutput("late.B.score", ifB.score, scoreBefore);
        checkOutput("late.A.pass", ifA.pass, 1);

        // Score rollover / saturation.
        applyStimulus(1'b0, 390, 1'b0, 1'b0, 1'b1);
        checkOutput("clr.score", ifA.score, 0);
        applyStimulus(1'b1, 390, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1'b1, 300, 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b1, 380, 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b1, 390, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("s255", ifA.score, 255);
        applyStimulus(1'b1, 300, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 380, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 390, 1'b0, 1'b1, 1'b0);
        checkOutput("s256.pass", ifA.pass, 1);
`ifdef LINE_HIT_SCORE_SAT_EN
        checkOutput("s256.score", ifA.score, 255);
`else
        checkOutput("s256.score", ifA.score, 0);
`endif
        applyStimulus(1'b1, 300, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 380, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 390, 1'b0, 1'b1, 1'b1);
        checkOutput("clrpass.pass", ifA.pass, 1);
        checkOutput("clrpass.score", ifA.score, 0);

        // Randomized traffic, including back-to-back frames and mid-frame resets.
        y = 300;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) y = 290 + $urandom_range(0, 110);
            rst = ($urandom_range(0, 299) == 0);
            ifA.frame       = ($urandom_range(0, 3) == 0);
            ifA.player_y    = 16'(y);
            ifA.h_line      = ($urandom_range(0, 29) == 0);
            ifA.player      = $urandom_range(0, 1) != 0;
            ifA.enable      = ($urandom_range(0, 39) != 0);
            ifA.clear_score = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
